// File: rtl/video_pkg.sv
// Shared constants and fill-FSM encoding for the game line scaler.
`timescale 1ns/1ps
package video_pkg;

    localparam int GAME_W = 256;
    localparam int GAME_H = 240;
    localparam int X_OFF  = 64;
    localparam int H_DISP = 640;
    localparam int V_DISP = 480;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line RAM: one write port, one registered read port, no reset.
`timescale 1ns/1ps
module line_buf_dp #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // A read colliding with a write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/game_line_scaler.sv
// 2x line/pixel doubler: ping-pong line banks filled from a line renderer,
// read out with one cycle of latency for the requested display coordinate.
`timescale 1ns/1ps
module game_line_scaler #(
    parameter int GAME_W = video_pkg::GAME_W,
    parameter int GAME_H = video_pkg::GAME_H,
    parameter int X_OFF  = video_pkg::X_OFF
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [11:0] pixel_xpos,
    input  logic [11:0] pixel_ypos,
    output logic [15:0] video_rgb_565,
    output logic        IsGameWindow,
    output logic        src_req,
    output logic [7:0]  src_line,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        underrun
);
    import video_pkg::*;

    localparam int          AW         = $clog2(GAME_W);
    localparam logic [11:0] X_FIRST    = 12'(X_OFF);
    localparam logic [11:0] X_LAST     = 12'(X_OFF + 2 * GAME_W - 1);
    localparam logic [11:0] Y_LAST     = 12'(2 * GAME_H);
    localparam logic [11:0] Y_LAST_ODD = 12'(2 * GAME_H - 1);
    localparam logic [11:0] X_END      = 12'(H_DISP - 1);
    localparam logic [11:0] Y_END      = 12'(V_DISP);
    localparam logic [11:0] G_LAST     = 12'(GAME_H - 1);
    localparam logic [AW-1:0] WR_LAST  = AW'(GAME_W - 1);

    fill_state_t   state_reg, state_next;
    logic [AW-1:0] wr_idx_reg, wr_idx_next;
    logic [7:0]    src_line_reg, src_line_next;
    logic          fill_bank_reg, fill_bank_next;
    logic          underrun_reg, underrun_next;
    logic          disp_bank_reg, disp_bank_next;
    logic          win_reg;

    logic          in_window;
    logic          line_start;
    logic          frame_end;
    logic          line_fill;
    logic          trigger;
    logic [11:0]   game_line;
    logic [7:0]    trig_line;
    logic [AW-1:0] rd_col;
    logic          wr_en;
    logic          ram_we;
    logic [15:0]   rd_data;

    // Display-side decode of the requested coordinate.
    assign in_window  = (pixel_xpos >= X_FIRST) && (pixel_xpos <= X_LAST) &&
                        (pixel_ypos >= 12'd1)   && (pixel_ypos <= Y_LAST);
    assign rd_col     = AW'((pixel_xpos - X_FIRST) >> 1);
    assign game_line  = (pixel_ypos - 12'd1) >> 1;

    // Line-start sits on the first (odd) display row of each game line.
    assign line_start = (pixel_xpos == 12'd0) && pixel_ypos[0] &&
                        (pixel_ypos <= Y_LAST_ODD);
    assign frame_end  = (pixel_xpos == X_END) && (pixel_ypos == Y_END);
    assign line_fill  = line_start && (game_line < G_LAST);
    assign trigger    = line_fill || frame_end;
    assign trig_line  = frame_end ? 8'd0 : 8'(game_line + 12'd1);

    assign disp_bank_next = line_start ? ~disp_bank_reg : disp_bank_reg;

    always_comb begin
        state_next     = state_reg;
        wr_idx_next    = wr_idx_reg;
        src_line_next  = src_line_reg;
        fill_bank_next = fill_bank_reg;
        underrun_next  = underrun_reg;
        wr_en          = 1'b0;
        if (trigger) begin
            // A new request while still filling means the source missed its slot.
            if (state_reg == ST_FILL) begin
                underrun_next = 1'b1;
            end
            state_next     = ST_FILL;
            wr_idx_next    = '0;
            src_line_next  = trig_line;
            fill_bank_next = ~disp_bank_next;
        end else if ((state_reg == ST_FILL) && src_valid) begin
            wr_en       = 1'b1;
            wr_idx_next = wr_idx_reg + AW'(1);
            if (wr_idx_reg == WR_LAST) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            wr_idx_reg    <= '0;
            src_line_reg  <= '0;
            fill_bank_reg <= 1'b0;
            underrun_reg  <= 1'b0;
            disp_bank_reg <= 1'b0;
            win_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_idx_reg    <= wr_idx_next;
            src_line_reg  <= src_line_next;
            fill_bank_reg <= fill_bank_next;
            underrun_reg  <= underrun_next;
            disp_bank_reg <= disp_bank_next;
            win_reg       <= in_window;
        end
    end

    assign ram_we = wr_en && !sys_rst;

    line_buf_dp #(
        .DW(16),
        .AW(AW + 1)
    ) u_line_buf (
        .clk    (pixel_clk),
        .wr_en  (ram_we),
        .wr_addr({fill_bank_reg, wr_idx_reg}),
        .wr_data(src_data),
        .rd_addr({disp_bank_reg, rd_col}),
        .rd_data(rd_data)
    );

    // The read data is already registered in the RAM; only blank it outside the window.
    assign video_rgb_565 = win_reg ? rd_data : 16'h0000;
    assign IsGameWindow  = win_reg;
    assign src_req       = (state_reg == ST_FILL);
    assign src_line      = src_line_reg;
    assign underrun      = underrun_reg;

endmodule

// File: tb/tb_game_line_scaler.sv
// Directed + randomized bench for game_line_scaler with a line-level bank model.
`timescale 1ns/1ps
module tb_game_line_scaler;

    logic        pixel_clk;
    logic        sys_rst;
    logic [11:0] pixel_xpos;
    logic [11:0] pixel_ypos;
    logic [15:0] video_rgb_565;
    logic        IsGameWindow;
    logic        src_req;
    logic [7:0]  src_line;
    logic        src_valid;
    logic [15:0] src_data;
    logic        underrun;

    game_line_scaler dut (
        .pixel_clk    (pixel_clk),
        .sys_rst      (sys_rst),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .video_rgb_565(video_rgb_565),
        .IsGameWindow (IsGameWindow),
        .src_req      (src_req),
        .src_line     (src_line),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .underrun     (underrun)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int errors = 0;
    int checks = 0;

    // Model: which game line each bank holds (-1 = unknown/corrupt).
    int bank_line [2];
    int disp;
    int in_fill;
    int fill_line;
    int fill_bank;
    int fill_cnt;
    int exp_underrun;
    int cur_row;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int x, input int y, input logic v, input logic [15:0] d);
        pixel_xpos = 12'(x);
        pixel_ypos = 12'(y);
        src_valid  = v;
        src_data   = d;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check_pix(input int x, input int y);
        int w;
        w = (x >= 64 && x <= 575 && y >= 1 && y <= 480) ? 1 : 0;
        chk($sformatf("win(%0d,%0d)", x, y), 32'(IsGameWindow), w);
        if (w == 0)
            chk($sformatf("rgb_out(%0d,%0d)", x, y), 32'(video_rgb_565), 0);
        else if (bank_line[disp] >= 0)
            chk($sformatf("rgb(%0d,%0d)", x, y), 32'(video_rgb_565),
                (bank_line[disp] * 256 + (x - 64) / 2) & 32'hFFFF);
    endtask

    task automatic check_state();
        chk("src_req", 32'(src_req), in_fill);
        if (in_fill != 0) chk("src_line", 32'(src_line), fill_line);
        chk("underrun", 32'(underrun), exp_underrun);
    endtask

    task automatic model_trigger(input int line);
        if (in_fill != 0) begin
            exp_underrun = 1;
            bank_line[fill_bank] = -1;
        end
        in_fill   = 1;
        fill_line = line;
        fill_bank = disp ^ 1;
        fill_cnt  = 0;
    endtask

    task automatic rand_req(output int x, output int y);
        if ($urandom_range(0, 7) == 0) begin
            x = 0;
            y = 0;
        end else begin
            x = $urandom_range(1, 638);
            y = (cur_row >= 480) ? 480 : cur_row + int'($urandom_range(0, 1));
        end
    endtask

    task automatic line_start(input int y);
        int g;
        g = (y - 1) / 2;
        step(0, y, 1'b0, 16'h0);
        check_pix(0, y);
        disp    = disp ^ 1;
        cur_row = y;
        if (g < 239) model_trigger(g + 1);
        check_state();
        $display("line-start ypos=%0d src_req=%0b src_line=%0d underrun=%0b",
                 y, src_req, src_line, underrun);
    endtask

    task automatic frame_end();
        step(639, 480, 1'b0, 16'h0);
        check_pix(639, 480);
        cur_row = 480;
        model_trigger(0);
        check_state();
        $display("frame-end src_req=%0b src_line=%0d underrun=%0b", src_req, src_line, underrun);
    endtask

    // Feed the pending fill (up to max_words valids), reading random pixels each cycle.
    task automatic run_fill(input int max_words, input int gaps);
        int x, y, words;
        logic v;
        logic [15:0] d;
        words = 0;
        while (in_fill != 0 && words < max_words) begin
            rand_req(x, y);
            v = (gaps == 0) || ($urandom_range(0, 3) != 0);
            d = v ? 16'(fill_line * 256 + fill_cnt) : 16'($urandom);
            step(x, y, v, d);
            check_pix(x, y);
            if (v) begin
                words++;
                fill_cnt++;
                if (fill_cnt == 256) begin
                    in_fill = 0;
                    bank_line[fill_bank] = fill_line;
                end
            end
            check_state();
        end
        $display("fill line=%0d words=%0d src_req=%0b underrun=%0b", fill_line, words, src_req, underrun);
    endtask

    // Random display reads; noisy=1 also drives src_valid with junk data.
    task automatic idle_cycles(input int n, input int noisy);
        int x, y;
        for (int i = 0; i < n; i++) begin
            rand_req(x, y);
            step(x, y, noisy != 0, 16'($urandom));
            check_pix(x, y);
            check_state();
        end
        $display("idle cycles=%0d noisy=%0d src_req=%0b underrun=%0b", n, noisy, src_req, underrun);
    endtask

    task automatic directed(input int x, input int y, input logic [15:0] er, input logic ew);
        step(x, y, 1'b0, 16'h0);
        chk($sformatf("dir_rgb(%0d,%0d)", x, y), 32'(video_rgb_565), 32'(er));
        chk($sformatf("dir_win(%0d,%0d)", x, y), 32'(IsGameWindow), 32'(ew));
        $display("read (%0d,%0d) rgb=0x%04h win=%0b", x, y, video_rgb_565, IsGameWindow);
    endtask

    initial begin
        bank_line[0] = -1;
        bank_line[1] = -1;
        disp = 0; in_fill = 0; fill_line = 0; fill_bank = 0; fill_cnt = 0;
        exp_underrun = 0; cur_row = 0;
        pixel_xpos = '0; pixel_ypos = '0; src_valid = 1'b0; src_data = '0;
        sys_rst = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_src_req", 32'(src_req), 0);
        chk("rst_src_line", 32'(src_line), 0);
        chk("rst_rgb", 32'(video_rgb_565), 0);
        chk("rst_win", 32'(IsGameWindow), 0);
        chk("rst_underrun", 32'(underrun), 0);
        sys_rst = 1'b0;

        idle_cycles(10, 1);

        // First frame: frame-end fill of line 0, then line 1.
        frame_end();
        run_fill(256, 1);
        line_start(1);
        run_fill(256, 1);
        directed(64, 1, 16'h0000, 1'b1);
        directed(65, 1, 16'h0000, 1'b1);
        directed(66, 2, 16'h0001, 1'b1);
        directed(63, 1, 16'h0000, 1'b0);
        directed(576, 1, 16'h0000, 1'b0);
        directed(100, 0, 16'h0000, 1'b0);

        // Line 2 fill, then junk valids while idle must not disturb it.
        line_start(3);
        run_fill(256, 1);
        idle_cycles(40, 1);
        line_start(5);
        run_fill(256, 1);
        for (int y = 7; y <= 13; y += 2) begin
            line_start(y);
            run_fill(256, 1);
        end

        // Bottom of the frame.
        line_start(477);
        run_fill(256, 1);
        line_start(479);
        directed(575, 480, 16'hEFFF, 1'b1);
        directed(575, 479, 16'hEFFF, 1'b1);
        directed(64, 479, 16'hEF00, 1'b1);
        directed(576, 480, 16'h0000, 1'b0);
        idle_cycles(30, 0);

        // Stalled source: next line-start flags underrun and restarts the fill.
        frame_end();
        run_fill(256, 1);
        line_start(1);
        run_fill(256, 1);
        line_start(3);
        idle_cycles(1700, 0);
        line_start(5);
        run_fill(256, 1);
        line_start(7);

        // Reset in the middle of a fill at write index 100.
        run_fill(100, 0);
        sys_rst = 1'b1;
        step(100, 7, 1'b0, 16'h0);
        sys_rst = 1'b0;
        in_fill = 0;
        bank_line[fill_bank] = -1;
        disp = 0;
        exp_underrun = 0;
        chk("midrst_src_req", 32'(src_req), 0);
        chk("midrst_src_line", 32'(src_line), 0);
        chk("midrst_underrun", 32'(underrun), 0);
        chk("midrst_rgb", 32'(video_rgb_565), 0);
        chk("midrst_win", 32'(IsGameWindow), 0);
        $display("reset mid-fill src_req=%0b underrun=%0b", src_req, underrun);

        line_start(9);
        run_fill(256, 1);
        line_start(11);
        run_fill(256, 1);
        idle_cycles(20, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
